// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush control for F/D, D/E, E/M, M/W registers, E-stage forwarding selects,
// data-cache miss wait with watchdog, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MissM,
  input  logic             RefillDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic            load_use_s;

  // M stage wins over W; x0 is a constant and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign load_use_s = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall/flush decode and next-state logic for the miss-wait FSM and watchdog.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (MissM) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          state_d = MEM_WAIT;
          wd_d    = '0;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use_s) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        wd_d = wd_q + WD_W'(1);
        // A refill arriving on the last watchdog cycle counts as a normal exit.
        if (RefillDone) begin
          state_d = RUN;
        end else if (wd_q == WD_LAST) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM, watchdog and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (FlushE && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a wide-counter instance and a short-watchdog/narrow-counter instance share stimulus
// and are checked against a cycle-level behavioural model, a vector table and hand-written sequences.
module tb_hazard_ctrl;

  localparam int TMO0 = 16;
  localparam int TMO1 = 4;
  localparam int CW1  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, PCSrcE, RegWriteM, RegWriteW, MissM, RefillDone;
  logic [1:0] ResultSrcE;

  logic StallF_a, StallD_a, StallE_a, StallM_a, FlushD_a, FlushE_a, mem_timeout_a;
  logic [1:0] ForwardAE_a, ForwardBE_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic StallF_b, StallD_b, StallE_b, StallM_b, FlushD_b, FlushE_b, mem_timeout_b;
  logic [1:0] ForwardAE_b, ForwardBE_b;
  logic [CW1-1:0] stall_cnt_b, flush_cnt_b;

  hazard_ctrl #(.CNT_W(32), .TIMEOUT(TMO0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MissM(MissM), .RefillDone(RefillDone),
    .StallF(StallF_a), .StallD(StallD_a), .StallE(StallE_a), .StallM(StallM_a),
    .FlushD(FlushD_a), .FlushE(FlushE_a), .ForwardAE(ForwardAE_a), .ForwardBE(ForwardBE_a),
    .mem_timeout(mem_timeout_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  hazard_ctrl #(.CNT_W(CW1), .TIMEOUT(TMO1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MissM(MissM), .RefillDone(RefillDone),
    .StallF(StallF_b), .StallD(StallD_b), .StallE(StallE_b), .StallM(StallM_b),
    .FlushD(FlushD_b), .FlushE(FlushE_b), .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b),
    .mem_timeout(mem_timeout_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  always #5 clk = ~clk;

  // packed order: StallF StallD StallE StallM FlushD FlushE ForwardAE ForwardBE
  typedef struct packed {
    logic sf, sd, se, sm, fd, fe;
    logic [1:0] fa, fb;
  } ctl_t;

  typedef struct {
    bit     waiting;
    int     waited;
    bit     to;
    longint sc;
    longint fc;
  } mst_t;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       rwe;
    logic [1:0] rse;
    logic       pc;
    logic [4:0] rdm, rdw;
    logic       rwm, rww;
    ctl_t       exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  mst_t m0, m1, m0n, m1n;
  ctl_t e0, e1;
  vec_t vt[12];

  logic [9:0] ctl_a, ctl_b;
  assign ctl_a = {StallF_a, StallD_a, StallE_a, StallM_a, FlushD_a, FlushE_a, ForwardAE_a, ForwardBE_a};
  assign ctl_b = {StallF_b, StallD_b, StallE_b, StallM_b, FlushD_b, FlushE_b, ForwardAE_b, ForwardBE_b};

  function automatic mst_t mreset();
    mst_t r;
    r.waiting = 1'b0; r.waited = 0; r.to = 1'b0; r.sc = 64'd0; r.fc = 64'd0;
    return r;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // One clock cycle of behaviour: outputs for the current inputs and the state after the edge.
  function automatic void model(input mst_t s, input int tmo, input longint cmax, output ctl_t o, output mst_t n);
    n = s;
    o = '0;
    o.fa = fwd_ref(Rs1E);
    o.fb = fwd_ref(Rs2E);
    if (s.waiting) begin
      {o.sf, o.sd, o.se, o.sm} = 4'b1111;
      n.waited = s.waited + 1;
      if (RefillDone) n.waiting = 1'b0;
      else if (n.waited == tmo) begin n.waiting = 1'b0; n.to = 1'b1; end
    end else if (MissM) begin
      {o.sf, o.sd, o.se, o.sm} = 4'b1111;
      n.waiting = 1'b1;
      n.waited  = 0;
    end else if (PCSrcE) begin
      o.fd = 1'b1; o.fe = 1'b1;
    end else if (ResultSrcE == 2'b01 && RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D)) begin
      o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
    end
    if (o.sf && s.sc < cmax) n.sc = s.sc + 1;
    if (o.fe && s.fc < cmax) n.fc = s.fc + 1;
  endfunction

  function automatic vec_t mkv(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, input logic rwe,
                               input logic [1:0] rse, input logic pc, input logic [4:0] rdm, rdw,
                               input logic rwm, rww, input logic [9:0] exp);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde; v.rwe = rwe;
    v.rse = rse; v.pc = pc; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteE = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MissM = 1'b0; RefillDone = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    m0 = mreset();
    m1 = mreset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Compare both instances with the model at the falling edge.
  task automatic step();
    @(negedge clk);
    model(m0, TMO0, 64'hFFFF_FFFF, e0, m0n);
    model(m1, TMO1, 64'd7, e1, m1n);
    chk("ctl_a", ctl_a, e0);
    chk("cnt_a", {mem_timeout_a, stall_cnt_a, flush_cnt_a}, {m0.to, m0.sc[31:0], m0.fc[31:0]});
    chk("ctl_b", ctl_b, e1);
    chk("cnt_b", {mem_timeout_b, stall_cnt_b, flush_cnt_b}, {m1.to, m1.sc[CW1-1:0], m1.fc[CW1-1:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m0 = m0n;
    m1 = m1n;
  endtask

  initial begin
    vt[0]  = mkv(5, 0, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 0, 10'b1100_01_00_00);
    vt[1]  = mkv(5, 0, 0, 0, 5, 1, 2'b01, 1, 0, 0, 0, 0, 10'b0000_11_00_00);
    vt[2]  = mkv(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 10'b0000_00_00_00);
    vt[3]  = mkv(0, 0, 7, 0, 0, 0, 2'b00, 0, 7, 7, 1, 1, 10'b0000_00_10_00);
    vt[4]  = mkv(0, 0, 7, 0, 0, 0, 2'b00, 0, 7, 7, 0, 1, 10'b0000_00_01_00);
    vt[5]  = mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 10'b0000_00_00_00);
    vt[6]  = mkv(0, 5, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 0, 10'b0000_00_00_00);
    vt[7]  = mkv(0, 5, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0, 10'b0000_00_00_00);
    vt[8]  = mkv(0, 5, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 0, 10'b1100_01_00_00);
    vt[9]  = mkv(0, 0, 3, 9, 0, 0, 2'b00, 0, 3, 9, 1, 1, 10'b0000_00_10_01);
    vt[10] = mkv(0, 0, 6, 6, 0, 0, 2'b00, 0, 6, 6, 1, 1, 10'b0000_00_10_10);
    vt[11] = mkv(4, 0, 0, 0, 4, 1, 2'b10, 0, 0, 0, 0, 0, 10'b0000_00_00_00);

    clear_inputs();
    rst_n = 1'b0;
    m0 = mreset();
    m1 = mreset();
    #12;
    chk("reset_ctl", ctl_a, 10'd0);
    chk("reset_cnt", {mem_timeout_a, stall_cnt_a, flush_cnt_a}, 65'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // vector table, all in RUN
    for (int i = 0; i < 12; i++) begin
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e; RdE = vt[i].rde;
      RegWriteE = vt[i].rwe; ResultSrcE = vt[i].rse; PCSrcE = vt[i].pc; RdM = vt[i].rdm; RdW = vt[i].rdw;
      RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
      step();
      chk($sformatf("vec%0d", i), ctl_a, vt[i].exp);
      tick();
    end
    chk("vec_stall_cnt", stall_cnt_a, 32'd2);
    chk("vec_flush_cnt", flush_cnt_a, 32'd3);

    // miss held 6 cycles with a taken branch in E, flushed on exit
    do_reset();
    PCSrcE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      MissM = (i == 0);
      RefillDone = (i == 5);
      step();
      chk("miss_stall", {StallF_a, StallE_a, StallM_a}, (i < 6) ? 3'b111 : 3'b000);
      chk("miss_flush", {FlushD_a, FlushE_a}, (i >= 6) ? 2'b11 : 2'b00);
      tick();
    end
    chk("miss_stall_cnt", stall_cnt_a, 32'd6);
    chk("miss_flush_cnt", flush_cnt_a, 32'd2);

    // watchdog expiry on the short instance
    do_reset();
    for (int i = 0; i < 6; i++) begin
      MissM = (i == 0);
      step();
      chk("wd_stall", StallF_b, (i < 5) ? 1'b1 : 1'b0);
      tick();
    end
    chk("wd_timeout", mem_timeout_b, 1'b1);
    repeat (3) begin step(); tick(); end
    chk("wd_sticky", mem_timeout_b, 1'b1);
    do_reset();
    chk("wd_cleared", mem_timeout_b, 1'b0);

    // refill on the final watchdog cycle is a normal exit
    for (int i = 0; i < 6; i++) begin
      MissM = (i == 0);
      RefillDone = (i == 4);
      step();
      chk("edge_stall", StallF_b, (i < 5) ? 1'b1 : 1'b0);
      tick();
    end
    chk("edge_no_timeout", mem_timeout_b, 1'b0);

    // async reset in the middle of a miss
    do_reset();
    MissM = 1'b1;
    step(); tick();
    MissM = 1'b0;
    step(); tick();
    chk("pre_rst_stall", StallM_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {ctl_a, ctl_b}, 20'd0);
    chk("async_rst_cnt", {stall_cnt_a, stall_cnt_b}, 35'd0);
    m0 = mreset();
    m1 = mreset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); tick();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      MissM = ($urandom_range(0, 7) == 0);
      RefillDone = ($urandom_range(0, 5) == 0);
      step();
      tick();
    end
    chk("sat_b", stall_cnt_b, 3'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
